// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and the lane helpers used on both the store and load paths.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        FAULT
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    // Reserved funct3 encodings fall through to a full-word access.
    function automatic access_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            SZ_BYTE: return BE_BYTE0 << off;
            SZ_HALF: return off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        case (size_of(f3))
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load path: picks the addressed byte/half lane out of the bus
// word and sign- or zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signExt;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half    = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_signExt = ~i_funct3[2];

        case (size_of(i_funct3))
            SZ_BYTE: o_data = {{24{w_byte[7] & w_signExt}}, w_byte};
            SZ_HALF: o_data = {{16{w_half[15] & w_signExt}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: issues one request/acknowledge bus
// transaction per load/store, stalls the PC meanwhile, and reports misalignment or timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  r_state;
    lsu_state_e  w_nextState;
    logic [7:0]  r_count;
    logic        r_busReq;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic        r_done;
    logic        r_misaligned;
    logic        r_busErr;
    logic [31:0] r_loadData;

    logic        w_access;
    logic        w_aligned;
    logic        w_expired;
    logic        w_acked;
    logic [31:0] w_alignedData;

    assign w_access  = mem_read | mem_write;
    assign w_aligned = is_aligned(funct3, addr[1:0]);
    assign w_expired = (r_count == LAST_COUNT);
    assign w_acked   = (r_state == BUSY) && bus_ack;

    load_align u_load_align (
        .i_rdata  (bus_rdata),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_alignedData)
    );

    // An ack arriving on the expiry cycle still completes the access.
    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    stall       = 1'b1;
                    w_nextState = w_aligned ? BUSY : FAULT;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ack) begin
                    w_nextState = DONE;
                end else if (w_expired) begin
                    w_nextState = FAULT;
                end
            end
            DONE:    w_nextState = IDLE;
            FAULT:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_count      <= 8'd0;
            r_busReq     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_funct3     <= 3'd0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_busErr     <= 1'b0;
            r_loadData   <= 32'd0;
        end else begin
            r_state      <= w_nextState;
            r_busReq     <= (w_nextState == BUSY);
            r_done       <= w_acked;
            r_busErr     <= (r_state == BUSY) && !bus_ack && w_expired;
            r_misaligned <= (r_state == IDLE) && w_access && !w_aligned;
            r_count      <= (r_state == BUSY) ? r_count + 8'd1 : 8'd0;

            // Stores report zero; the extracted lane lives only for the DONE cycle.
            r_loadData <= (w_acked && !r_we) ? w_alignedData : 32'd0;

            if ((r_state == IDLE) && w_access && w_aligned) begin
                r_we     <= mem_write;
                r_addr   <= addr;
                r_be     <= byte_enables(funct3, addr[1:0]);
                r_wdata  <= store_lanes(funct3, store_data);
                r_funct3 <= funct3;
            end
        end
    end

    assign bus_req    = r_busReq;
    assign bus_we     = r_we;
    assign bus_addr   = {r_addr[31:2], 2'b00};
    assign bus_wdata  = r_wdata;
    assign bus_be     = r_be;
    assign done       = r_done;
    assign misaligned = r_misaligned;
    assign bus_err    = r_busErr;
    assign load_data  = r_loadData;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the access rules
// plus randomized loads/stores compared with an arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;

    int nChecks = 0;
    int nFails  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .done       (done),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: access width in bytes, from the funct3 table.
    function automatic int accessSize(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int lane;
        sz   = accessSize(f3);
        lane = int'(a[1:0]);
        if (sz == 1) return 4'(1 << lane);
        if (sz == 2) return 4'(3 << (lane / 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz;
        sz = accessSize(f3);
        if (sz == 1) return (rs2 & 32'hFF) * 32'h01010101;
        if (sz == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int     sz;
        int     lane;
        longint u;
        longint v;
        sz = accessSize(f3);
        if (sz == 4) return rd;
        lane = (sz == 1) ? int'(a[1:0]) : int'(a[1:0]) / 2 * 2;
        u    = longint'(rd);
        v    = (u >> (8 * lane)) & ((64'sd1 << (8 * sz)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
        return 32'(v);
    endfunction

    // One complete access starting in IDLE; waits = bus cycles before ack (>= TO means no ack).
    task automatic applyStimulus(input bit isWrite, input bit isRead, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] rs2, input int waits,
                                 input logic [31:0] rd, input string tag);
        bit we;
        bit aligned;
        int busyCycles;
        we      = isWrite;
        aligned = (int'(a[1:0]) % accessSize(f3)) == 0;

        @(negedge clk);
        mem_write  = isWrite;
        mem_read   = isRead;
        funct3     = f3;
        addr       = a;
        store_data = rs2;
        bus_ack    = 1'b0;
        #1 checkOutput({tag, " stall_idle"}, 32'(stall), 32'd1);

        if (!aligned) begin
            @(negedge clk);
            #1;
            checkOutput({tag, " misaligned"}, 32'(misaligned), 32'd1);
            checkOutput({tag, " done"}, 32'(done), 32'd0);
            checkOutput({tag, " bus_err"}, 32'(bus_err), 32'd0);
            checkOutput({tag, " load_data"}, load_data, 32'd0);
            checkOutput({tag, " stall_end"}, 32'(stall), 32'd0);
            checkOutput({tag, " bus_req_end"}, 32'(bus_req), 32'd0);
        end else begin
            busyCycles = (waits < TO) ? waits + 1 : TO;
            for (int k = 0; k < busyCycles; k++) begin
                @(negedge clk);
                bus_ack   = (k == waits);
                bus_rdata = (k == waits) ? rd : $urandom;
                #1;
                checkOutput({tag, " stall_busy"}, 32'(stall), 32'd1);
                checkOutput({tag, " bus_req"}, 32'(bus_req), 32'd1);
                checkOutput({tag, " bus_we"}, 32'(bus_we), 32'(we));
                checkOutput({tag, " bus_addr"}, bus_addr, a & ~32'd3);
                checkOutput({tag, " bus_be"}, 32'(bus_be), 32'(modelBe(f3, a)));
                if (we) checkOutput({tag, " bus_wdata"}, bus_wdata, modelWdata(f3, rs2));
            end
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            #1;
            if (waits < TO) begin
                checkOutput({tag, " done"}, 32'(done), 32'd1);
                checkOutput({tag, " bus_err"}, 32'(bus_err), 32'd0);
                checkOutput({tag, " load_data"}, load_data, we ? 32'd0 : modelLoad(f3, a, rd));
            end else begin
                checkOutput({tag, " bus_err"}, 32'(bus_err), 32'd1);
                checkOutput({tag, " done"}, 32'(done), 32'd0);
                checkOutput({tag, " load_data"}, load_data, 32'd0);
            end
            checkOutput({tag, " misaligned"}, 32'(misaligned), 32'd0);
            checkOutput({tag, " stall_end"}, 32'(stall), 32'd0);
            checkOutput({tag, " bus_req_end"}, 32'(bus_req), 32'd0);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " bus_req"}, 32'(bus_req), 32'd0);
        checkOutput({tag, " bus_we"}, 32'(bus_we), 32'd0);
        checkOutput({tag, " bus_addr"}, bus_addr, 32'd0);
        checkOutput({tag, " bus_wdata"}, bus_wdata, 32'd0);
        checkOutput({tag, " bus_be"}, 32'(bus_be), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " misaligned"}, 32'(misaligned), 32'd0);
        checkOutput({tag, " bus_err"}, 32'(bus_err), 32'd0);
        checkOutput({tag, " load_data"}, load_data, 32'd0);
        checkOutput({tag, " stall"}, 32'(stall), 32'd0);
    endtask

    logic [2:0] f3Codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          mode;

        // Reset with a load pending: stall must stay low while rst=0.
        rst      = 1'b0;
        mem_read = 1'b1;
        repeat (2) @(negedge clk);
        #1 checkAllZero("reset");
        mem_read = 1'b0;
        rst      = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'd0, "sw");
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h203, 32'd0, 3, 32'h80FF7F01, "lb");
        applyStimulus(1'b0, 1'b1, 3'd4, 32'h203, 32'd0, 3, 32'h80FF7F01, "lbu");
        applyStimulus(1'b1, 1'b0, 3'd1, 32'h302, 32'h1234ABCD, 1, 32'd0, "sh");
        applyStimulus(1'b0, 1'b1, 3'd5, 32'h302, 32'd0, 1, 32'hBEEF0000, "lhu");
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h101, 32'd0, 0, 32'd0, "lw_mis");
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h7, 32'h000000A5, 0, 32'd0, "both_sb");
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h400, 32'd0, 10, 32'd0, "lw_timeout");

        // Late ack after a timeout must not produce a completion.
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        #1 checkOutput("late_ack stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("late_ack done", 32'(done), 32'd0);
        checkOutput("late_ack bus_req", 32'(bus_req), 32'd0);
        checkOutput("late_ack bus_err", 32'(bus_err), 32'd0);
        bus_ack = 1'b0;

        // Reset while BUSY abandons the request.
        @(negedge clk);
        mem_write  = 1'b1;
        funct3     = 3'd2;
        addr       = 32'h500;
        store_data = 32'hCAFEF00D;
        @(negedge clk);
        #1 checkOutput("rst_busy bus_req", 32'(bus_req), 32'd1);
        rst       = 1'b0;
        mem_write = 1'b0;
        #1 checkOutput("rst_busy stall", 32'(stall), 32'd0);
        @(negedge clk);
        bus_ack = 1'b1;
        rst     = 1'b1;
        #1 checkAllZero("rst_busy");
        @(negedge clk);
        #1;
        checkOutput("rst_late done", 32'(done), 32'd0);
        checkOutput("rst_late bus_req", 32'(bus_req), 32'd0);
        bus_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h601, 32'h0000005A, 2, 32'd0, "sb_after_rst");

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            f3   = f3Codes[$urandom_range(0, 7)];
            a    = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(accessSize(f3)) - 32'd1);
            mode = $urandom_range(0, 2);
            applyStimulus(mode != 0, mode != 1, f3, a, $urandom, $urandom_range(0, 5), $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
